openhw_ebu_arb: RTL and testbench
=================================

Name: openhw_ebu_arb

Overview:
- Two-manager AHB-Lite arbiter. It sits directly downstream of the two single-beat bus FSMs: IFU is manager 0 and LSU is manager 1.
- Merges their NONSEQ requests onto the single external AHB manager port.
- A request that loses arbitration is captured in a per-manager hold stage and replayed later. The losing manager sees its HREADY held low until its data phase completes.
- LSU has priority, with a bounded-starvation guarantee for the IFU.

Parameters:
- PA_BITS, 34, physical address width.
- AHBW, 64, AHB data width.
- MAX_LSU_WINS, 4, consecutive LSU grants allowed while an IFU request waits. Legal range 1..15.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- IFUHTRANS  in  2  IFU transfer type (00 IDLE, 10 NONSEQ).
- IFUHADDR  in  PA_BITS  IFU address.
- IFUHSIZE  in  3  IFU transfer size.
- IFUHREADY  out  1  ready returned to IFU.
- LSUHTRANS  in  2  LSU transfer type.
- LSUHADDR  in  PA_BITS  LSU address.
- LSUHSIZE  in  3  LSU size.
- LSUHWRITE  in  1  LSU write.
- LSUHWDATA  in  AHBW  LSU write data, data phase.
- LSUHWSTRB  in  AHBW/8  LSU byte strobes, data phase.
- LSUHREADY  out  1  ready returned to LSU.
- HREADY  in  1  subordinate ready.
- HTRANS  out  2  bus transfer type.
- HADDR  out  PA_BITS  bus address.
- HSIZE  out  3  bus size.
- HWRITE  out  1  bus write; always 0 for IFU.
- HWDATA  out  AHBW  bus write data.
- HWSTRB  out  AHBW/8  bus strobes.

HRDATA goes from the bus to both managers directly and is not routed through this block.

Behaviour:
- Clocking and reset: one clock, HCLK; reset is asynchronous and active-low (HRESETn).
- Reset values while HRESETn=0:
  - Hold stages: Valid=0, saved fields 0.
  - DataOwner=NONE.
  - LsuWins=0.
  - HTRANS=00 regardless of inputs.
  - IFUHREADY=LSUHREADY=0.
  - HADDR, HSIZE, HWRITE, HWDATA, HWSTRB = 0.
- Request presentation, per manager m:
  - Live request: mHTRANS=10 while mHREADY=1.
  - Req_m = Valid_m | live request.
  - Presented fields come from the saved copy when Valid_m=1, else from the live inputs.
- Grant:
  - Evaluated only in cycles with HREADY=1.
  - If only one Req is set, that manager wins.
  - If both are set, LSU wins unless LsuWins==MAX_LSU_WINS, in which case IFU wins.
  - On a grant: HTRANS=10 and HADDR/HSIZE/HWRITE come from the winner.
  - Otherwise: HTRANS=00, and address fields still show the LSU-preferred mux (don't-care).
- Capture: a live request that is not granted this cycle sets Valid_m and saves ADDR/SIZE/WRITE at the clock edge. Valid_m clears at the edge where manager m is granted. A captured request is never dropped.
- DataOwner register (NONE/IFU/LSU): at each edge with HREADY=1 it loads the granted manager, or NONE if there was no grant. It holds when HREADY=0.
- Manager ready:
  - If DataOwner==m: mHREADY = HREADY.
  - Otherwise: mHREADY = ~Valid_m.
  - A manager with a pending captured request therefore sees 0 until its own data phase completes.
- Write data: HWDATA/HWSTRB = LSU values when DataOwner==LSU, else 0.
- LsuWins counter (4 bits):
  - Increments on an LSU grant while Req_IFU=1.
  - Clears on an IFU grant, or on any HREADY=1 cycle with Req_IFU=0.
  - Saturates at MAX_LSU_WINS.
- Latency:
  - A granted live request reaches the bus in the same cycle, with zero added cycles.
  - A captured request is issued at the first HREADY=1 cycle in which it wins.
- Boundary conditions:
  - Both managers request in the same cycle → one grant, one capture.
  - New live requests cannot arise while Valid_m=1, because mHREADY=0.
  - HREADY low for many cycles → all state holds.
  - HRESETn asserted mid-transfer → immediate return to reset values; pending captures are lost.
- Assertions:
  - Never Valid_m=1 together with a live request from m.
  - HTRANS is only ever 00 or 10.

Decomposition:
- Shared package ebu_pkg:
  - ahbtranstype enum (IDLE/BUSY/NONSEQ/SEQ).
  - ownertype enum (NONE/IFU/LSU).
- Sub-module openhw_ahb_req_hold, instantiated per manager: Valid flag, saved ADDR/SIZE/WRITE, and the output mux.
- Grant logic, DataOwner, and LsuWins live in the top module.

Test Plan:
- Single IFU read at 0x8000_0000, HREADY=1 → HTRANS=10 and HADDR=0x8000_0000 in the same cycle; next cycle IFUHREADY follows HREADY; LSUHREADY=1.
- IFU and LSU both NONSEQ in one cycle (IFU 0x1000, LSU write 0x2000, HWDATA=0xDEAD_BEEF) → LSU issued first and HWDATA=0xDEAD_BEEF in its data phase; IFUHREADY=0 until IFU 0x1000 is issued at the next HREADY=1 and its data phase completes.
- HREADY held 0 for 3 cycles during an LSU data phase while IFU is captured → no bus change, IFU Valid holds, LSUHREADY=0 for 3 cycles.
- LSU requests every available cycle with IFU pending and MAX_LSU_WINS=4 → exactly 4 LSU grants, then an IFU grant, LsuWins returns to 0.
- HRESETn pulsed low while an IFU request is captured and DataOwner=LSU → outputs immediately at reset values, Valid=0, HTRANS=00 even with inputs at NONSEQ.
- Random back-to-back traffic, 10k cycles, against an AHB subordinate model with random wait states → every accepted request appears exactly once on the bus in arbitration order; no assertion fires.

Source files
------------

// File: rtl/ebu_pkg.sv
// Shared types for the external bus unit arbiter: AHB transfer encodings
// and the data-phase owner.
package ebu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } ahbtranstype;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        IFU  = 2'b01,
        LSU  = 2'b10
    } ownertype;

    localparam int LSU_WINS_BITS = 4;

endpackage

// File: rtl/openhw_ahb_req_hold.sv
// Per-manager hold stage: captures a live request that lost arbitration and
// presents either the saved copy or the live address-phase fields.
module openhw_ahb_req_hold
    import ebu_pkg::*;
#(
    parameter int PA_BITS = 34
)
(
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic [1:0]         htrans,
    input  logic [PA_BITS-1:0] haddr,
    input  logic [2:0]         hsize,
    input  logic               hwrite,
    input  logic               hready_mgr,
    input  logic               grant,
    output logic               live,
    output logic               valid,
    output logic               req,
    output logic [PA_BITS-1:0] addr,
    output logic [2:0]         size,
    output logic               write
);

    logic [PA_BITS-1:0] saved_addr;
    logic [2:0]         saved_size;
    logic               saved_write;

    assign live = (htrans == NONSEQ) && hready_mgr;
    assign req  = valid || live;

    // A grant always retires the presented request; an ungranted live one is kept.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid       <= 1'b0;
            saved_addr  <= '0;
            saved_size  <= '0;
            saved_write <= 1'b0;
        end else if (grant) begin
            valid <= 1'b0;
        end else if (live) begin
            valid       <= 1'b1;
            saved_addr  <= haddr;
            saved_size  <= hsize;
            saved_write <= hwrite;
        end
    end

    always_comb begin
        addr  = valid ? saved_addr  : haddr;
        size  = valid ? saved_size  : hsize;
        write = valid ? saved_write : hwrite;
    end

endmodule

// File: rtl/openhw_ebu_arb.sv
// Two-manager AHB-Lite arbiter (IFU = manager 0, LSU = manager 1). LSU has
// priority, but an IFU request waits for at most MAX_LSU_WINS LSU grants.
module openhw_ebu_arb
    import ebu_pkg::*;
#(
    parameter int PA_BITS      = 34,
    parameter int AHBW         = 64,
    parameter int MAX_LSU_WINS = 4
)
(
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic [1:0]          IFUHTRANS,
    input  logic [PA_BITS-1:0]  IFUHADDR,
    input  logic [2:0]          IFUHSIZE,
    output logic                IFUHREADY,
    input  logic [1:0]          LSUHTRANS,
    input  logic [PA_BITS-1:0]  LSUHADDR,
    input  logic [2:0]          LSUHSIZE,
    input  logic                LSUHWRITE,
    input  logic [AHBW-1:0]     LSUHWDATA,
    input  logic [AHBW/8-1:0]   LSUHWSTRB,
    output logic                LSUHREADY,
    input  logic                HREADY,
    output logic [1:0]          HTRANS,
    output logic [PA_BITS-1:0]  HADDR,
    output logic [2:0]          HSIZE,
    output logic                HWRITE,
    output logic [AHBW-1:0]     HWDATA,
    output logic [AHBW/8-1:0]   HWSTRB
);

    localparam logic [LSU_WINS_BITS-1:0] WINS_MAX = LSU_WINS_BITS'(MAX_LSU_WINS);

    logic               ifu_live, ifu_valid, ifu_req, ifu_write;
    logic               lsu_live, lsu_valid, lsu_req, lsu_write;
    logic [PA_BITS-1:0] ifu_addr, lsu_addr;
    logic [2:0]         ifu_size, lsu_size;
    logic               gnt_ifu, gnt_lsu;
    ownertype           owner_q, owner_d;
    logic [LSU_WINS_BITS-1:0] lsu_wins;

    openhw_ahb_req_hold #(.PA_BITS(PA_BITS)) u_ifu_hold (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .htrans     (IFUHTRANS),
        .haddr      (IFUHADDR),
        .hsize      (IFUHSIZE),
        .hwrite     (1'b0),
        .hready_mgr (IFUHREADY),
        .grant      (gnt_ifu),
        .live       (ifu_live),
        .valid      (ifu_valid),
        .req        (ifu_req),
        .addr       (ifu_addr),
        .size       (ifu_size),
        .write      (ifu_write)
    );

    openhw_ahb_req_hold #(.PA_BITS(PA_BITS)) u_lsu_hold (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .htrans     (LSUHTRANS),
        .haddr      (LSUHADDR),
        .hsize      (LSUHSIZE),
        .hwrite     (LSUHWRITE),
        .hready_mgr (LSUHREADY),
        .grant      (gnt_lsu),
        .live       (lsu_live),
        .valid      (lsu_valid),
        .req        (lsu_req),
        .addr       (lsu_addr),
        .size       (lsu_size),
        .write      (lsu_write)
    );

    // LSU wins ties until it has starved a waiting IFU request WINS_MAX times.
    always_comb begin
        gnt_ifu = 1'b0;
        gnt_lsu = 1'b0;
        if (HREADY && HRESETn) begin
            if (lsu_req && (!ifu_req || (lsu_wins != WINS_MAX))) begin
                gnt_lsu = 1'b1;
            end else if (ifu_req) begin
                gnt_ifu = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lsu_wins <= '0;
        end else if (HREADY) begin
            if (gnt_lsu && ifu_req) begin
                if (lsu_wins != WINS_MAX) begin
                    lsu_wins <= lsu_wins + 1'b1;
                end
            end else begin
                lsu_wins <= '0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_q <= NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        owner_d = owner_q;
        if (HREADY) begin
            if (gnt_lsu) begin
                owner_d = LSU;
            end else if (gnt_ifu) begin
                owner_d = IFU;
            end else begin
                owner_d = NONE;
            end
        end
    end

    // A manager with a captured request stays stalled until its own data phase ends.
    always_comb begin
        IFUHREADY = HRESETn && ((owner_q == IFU) ? HREADY : !ifu_valid);
        LSUHREADY = HRESETn && ((owner_q == LSU) ? HREADY : !lsu_valid);
        HWDATA    = (owner_q == LSU) ? LSUHWDATA : '0;
        HWSTRB    = (owner_q == LSU) ? LSUHWSTRB : '0;
        HTRANS    = (gnt_ifu || gnt_lsu) ? NONSEQ : IDLE;
        HADDR     = '0;
        HSIZE     = '0;
        HWRITE    = 1'b0;
        if (HRESETn) begin
            HADDR  = gnt_ifu ? ifu_addr  : lsu_addr;
            HSIZE  = gnt_ifu ? ifu_size  : lsu_size;
            HWRITE = gnt_ifu ? ifu_write : lsu_write;
        end
    end

    a_hold_excl_ifu: assert property (@(posedge HCLK) disable iff (!HRESETn)
        !(ifu_valid && ifu_live));
    a_hold_excl_lsu: assert property (@(posedge HCLK) disable iff (!HRESETn)
        !(lsu_valid && lsu_live));
    a_htrans_legal: assert property (@(posedge HCLK) disable iff (!HRESETn)
        (HTRANS == IDLE) || (HTRANS == NONSEQ));

endmodule

// File: tb/tb_openhw_ebu_arb.sv
// Self-checking bench for openhw_ebu_arb: reference arbitration model with
// per-manager scoreboards, directed scenarios and random traffic with wait states.
module tb_openhw_ebu_arb;
    import ebu_pkg::*;

    localparam int PA_BITS      = 34;
    localparam int AHBW         = 64;
    localparam int MAX_LSU_WINS = 4;

    logic                HCLK = 1'b0;
    logic                HRESETn;
    logic [1:0]          IFUHTRANS;
    logic [PA_BITS-1:0]  IFUHADDR;
    logic [2:0]          IFUHSIZE;
    logic                IFUHREADY;
    logic [1:0]          LSUHTRANS;
    logic [PA_BITS-1:0]  LSUHADDR;
    logic [2:0]          LSUHSIZE;
    logic                LSUHWRITE;
    logic [AHBW-1:0]     LSUHWDATA;
    logic [AHBW/8-1:0]   LSUHWSTRB;
    logic                LSUHREADY;
    logic                HREADY;
    logic [1:0]          HTRANS;
    logic [PA_BITS-1:0]  HADDR;
    logic [2:0]          HSIZE;
    logic                HWRITE;
    logic [AHBW-1:0]     HWDATA;
    logic [AHBW/8-1:0]   HWSTRB;

    typedef struct {
        logic [PA_BITS-1:0] addr;
        logic [2:0]         size;
        logic               write;
    } req_t;

    req_t               ifu_q[$];
    req_t               lsu_q[$];
    logic [PA_BITS-1:0] bus_log[$];
    int                 m_owner;
    int                 m_wins;
    logic               m_ifu_rdy;
    logic               m_lsu_rdy;
    int                 checks = 0;
    int                 fails  = 0;

    always #5 HCLK = ~HCLK;

    openhw_ebu_arb #(
        .PA_BITS      (PA_BITS),
        .AHBW         (AHBW),
        .MAX_LSU_WINS (MAX_LSU_WINS)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .IFUHTRANS (IFUHTRANS),
        .IFUHADDR  (IFUHADDR),
        .IFUHSIZE  (IFUHSIZE),
        .IFUHREADY (IFUHREADY),
        .LSUHTRANS (LSUHTRANS),
        .LSUHADDR  (LSUHADDR),
        .LSUHSIZE  (LSUHSIZE),
        .LSUHWRITE (LSUHWRITE),
        .LSUHWDATA (LSUHWDATA),
        .LSUHWSTRB (LSUHWSTRB),
        .LSUHREADY (LSUHREADY),
        .HREADY    (HREADY),
        .HTRANS    (HTRANS),
        .HADDR     (HADDR),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HWSTRB    (HWSTRB)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Sample at the falling edge, compare against the model, then advance the model.
    task automatic runCycle();
        req_t r;
        bit   ifu_req, lsu_req;
        int   win;
        @(negedge HCLK);
        m_ifu_rdy = (m_owner == 1) ? HREADY : (ifu_q.size() == 0);
        m_lsu_rdy = (m_owner == 2) ? HREADY : (lsu_q.size() == 0);
        checkOutput("IFUHREADY", 64'(IFUHREADY), 64'(m_ifu_rdy));
        checkOutput("LSUHREADY", 64'(LSUHREADY), 64'(m_lsu_rdy));
        checkOutput("HWDATA", HWDATA, (m_owner == 2) ? LSUHWDATA : 64'd0);
        checkOutput("HWSTRB", 64'(HWSTRB), (m_owner == 2) ? 64'(LSUHWSTRB) : 64'd0);
        if (IFUHTRANS == 2'b10 && m_ifu_rdy) begin
            r.addr = IFUHADDR; r.size = IFUHSIZE; r.write = 1'b0;
            ifu_q.push_back(r);
        end
        if (LSUHTRANS == 2'b10 && m_lsu_rdy) begin
            r.addr = LSUHADDR; r.size = LSUHSIZE; r.write = LSUHWRITE;
            lsu_q.push_back(r);
        end
        ifu_req = (ifu_q.size() != 0);
        lsu_req = (lsu_q.size() != 0);
        win = 0;
        if (HREADY) begin
            if (lsu_req && (!ifu_req || m_wins != MAX_LSU_WINS)) win = 2;
            else if (ifu_req) win = 1;
        end
        checkOutput("HTRANS", 64'(HTRANS), (win != 0) ? 64'h2 : 64'h0);
        if (HTRANS == 2'b10 && HREADY) bus_log.push_back(HADDR);
        if (win != 0) begin
            if (win == 1) r = ifu_q.pop_front();
            else          r = lsu_q.pop_front();
            checkOutput("HADDR", 64'(HADDR), 64'(r.addr));
            checkOutput("HSIZE", 64'(HSIZE), 64'(r.size));
            checkOutput("HWRITE", 64'(HWRITE), 64'(r.write));
        end
        if (HREADY) begin
            if (win == 2 && ifu_req) begin
                if (m_wins < MAX_LSU_WINS) m_wins++;
            end else begin
                m_wins = 0;
            end
            m_owner = win;
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] it, input logic [PA_BITS-1:0] ia,
                                 input logic [1:0] lt, input logic [PA_BITS-1:0] la,
                                 input logic lw, input logic [AHBW-1:0] wd, input logic hr);
        IFUHTRANS = it;  IFUHADDR = ia;  IFUHSIZE = 3'd2;
        LSUHTRANS = lt;  LSUHADDR = la;  LSUHSIZE = 3'd3;
        LSUHWRITE = lw;  LSUHWDATA = wd; LSUHWSTRB = 8'h0F;
        HREADY = hr;
        runCycle();
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_HTRANS", 64'(HTRANS), 64'h0);
        checkOutput("rst_IFUHREADY", 64'(IFUHREADY), 64'h0);
        checkOutput("rst_LSUHREADY", 64'(LSUHREADY), 64'h0);
        checkOutput("rst_HADDR", 64'(HADDR), 64'h0);
        checkOutput("rst_HSIZE", 64'(HSIZE), 64'h0);
        checkOutput("rst_HWRITE", 64'(HWRITE), 64'h0);
        checkOutput("rst_HWDATA", HWDATA, 64'h0);
        checkOutput("rst_HWSTRB", 64'(HWSTRB), 64'h0);
    endtask

    // Assert reset mid-cycle with both managers requesting; release away from the edge.
    task automatic doReset();
        #2;
        HRESETn   = 1'b0;
        IFUHTRANS = 2'b10; IFUHADDR = 34'h1_2345_6780;
        LSUHTRANS = 2'b10; LSUHADDR = 34'h2_0000_0040; LSUHWRITE = 1'b1;
        LSUHWDATA = 64'h0123_4567_89AB_CDEF; LSUHWSTRB = 8'hFF;
        HREADY    = 1'b1;
        #1;
        checkResetOutputs();
        ifu_q.delete();
        lsu_q.delete();
        m_owner   = 0;
        m_wins    = 0;
        m_ifu_rdy = 1'b1;
        m_lsu_rdy = 1'b1;
        @(posedge HCLK);
        @(posedge HCLK);
        #2;
        checkResetOutputs();
        IFUHTRANS = 2'b00;
        LSUHTRANS = 2'b00;
        HRESETn   = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [AHBW-1:0] zero_d = '0;
        m_owner = 0; m_wins = 0; m_ifu_rdy = 1'b1; m_lsu_rdy = 1'b1;
        HRESETn = 1'b0;
        HREADY = 1'b1;
        IFUHTRANS = 2'b00; IFUHADDR = '0; IFUHSIZE = '0;
        LSUHTRANS = 2'b00; LSUHADDR = '0; LSUHSIZE = '0; LSUHWRITE = 1'b0;
        LSUHWDATA = '0; LSUHWSTRB = '0;
        @(posedge HCLK);
        #1;
        doReset();

        $display("[TB] single IFU read");
        applyStimulus(2'b10, 34'h0_8000_0000, 2'b00, '0, 1'b0, zero_d, 1'b1);
        applyStimulus(2'b00, '0, 2'b00, '0, 1'b0, zero_d, 1'b0);
        applyStimulus(2'b00, '0, 2'b00, '0, 1'b0, zero_d, 1'b1);
        applyStimulus(2'b00, '0, 2'b00, '0, 1'b0, zero_d, 1'b1);

        $display("[TB] simultaneous IFU and LSU requests");
        applyStimulus(2'b10, 34'h1000, 2'b10, 34'h2000, 1'b1, zero_d, 1'b1);
        applyStimulus(2'b10, 34'h1000, 2'b00, '0, 1'b0, 64'hDEAD_BEEF, 1'b1);
        applyStimulus(2'b00, '0, 2'b00, '0, 1'b0, zero_d, 1'b1);
        applyStimulus(2'b00, '0, 2'b00, '0, 1'b0, zero_d, 1'b1);

        $display("[TB] wait states during LSU data phase");
        applyStimulus(2'b10, 34'h5000, 2'b10, 34'h6000, 1'b0, zero_d, 1'b1);
        for (int i = 0; i < 3; i++)
            applyStimulus(2'b10, 34'h5000, 2'b00, '0, 1'b0, zero_d, 1'b0);
        applyStimulus(2'b10, 34'h5000, 2'b00, '0, 1'b0, zero_d, 1'b1);
        applyStimulus(2'b00, '0, 2'b00, '0, 1'b0, zero_d, 1'b1);
        applyStimulus(2'b00, '0, 2'b00, '0, 1'b0, zero_d, 1'b1);

        $display("[TB] bounded IFU starvation");
        n = bus_log.size();
        for (int i = 0; i < 5; i++)
            applyStimulus(2'b10, 34'h3000, 2'b10, 34'(34'h4000 + i * 8), 1'b0, zero_d, 1'b1);
        applyStimulus(2'b00, '0, 2'b00, '0, 1'b0, zero_d, 1'b1);
        applyStimulus(2'b00, '0, 2'b00, '0, 1'b0, zero_d, 1'b1);
        if (bus_log.size() < n + 6) begin
            checkOutput("starve_count", 64'(bus_log.size() - n), 64'd6);
        end else begin
            for (int i = 0; i < 4; i++)
                checkOutput("starve_lsu", 64'(bus_log[n + i]), 64'(34'h4000 + i * 8));
            checkOutput("starve_ifu", 64'(bus_log[n + 4]), 64'h3000);
            checkOutput("starve_lsu_late", 64'(bus_log[n + 5]), 64'h4020);
        end

        $display("[TB] reset while a capture is pending");
        applyStimulus(2'b10, 34'h7000, 2'b10, 34'h8000, 1'b1, zero_d, 1'b1);
        doReset();
        applyStimulus(2'b00, '0, 2'b00, '0, 1'b0, zero_d, 1'b1);
        applyStimulus(2'b00, '0, 2'b00, '0, 1'b0, zero_d, 1'b1);

        $display("[TB] random traffic");
        for (int c = 0; c < 10000; c++) begin
            if (m_ifu_rdy) begin
                IFUHTRANS = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
                IFUHADDR  = {2'($urandom_range(0, 3)), 32'($urandom)};
                IFUHSIZE  = 3'($urandom_range(0, 3));
            end
            if (m_lsu_rdy) begin
                LSUHTRANS = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
                LSUHADDR  = {2'($urandom_range(0, 3)), 32'($urandom)};
                LSUHSIZE  = 3'($urandom_range(0, 3));
                LSUHWRITE = 1'($urandom_range(0, 1));
            end
            LSUHWDATA = {32'($urandom), 32'($urandom)};
            LSUHWSTRB = 8'($urandom);
            HREADY    = ($urandom_range(0, 3) != 0);
            runCycle();
        end
        HREADY = 1'b1;
        IFUHTRANS = 2'b00;
        LSUHTRANS = 2'b00;
        for (int i = 0; i < 4; i++) runCycle();
        checkOutput("drain_ifu", 64'(ifu_q.size()), 64'd0);
        checkOutput("drain_lsu", 64'(lsu_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
